// File: rtl/encoder_frontend.sv
`default_nettype none
// ============================================================================
// Module      : encoder_frontend
// Description : Quadrature encoder conditioning for the ESC speed loop.
//               Synchronises and deglitches A/B, decodes signed position and
//               direction, measures the clock period between filtered A
//               rising edges, and flags stalls and illegal transitions.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_frontend #(
    parameter int          DATA_WIDTH = 16,
    parameter int          FILTER_LEN = 3,
    parameter int unsigned TIMEOUT    = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  encoder_a,
    input  logic                  encoder_b,
    input  logic                  clear_pos,
    output logic [DATA_WIDTH-1:0] position,
    output logic [1:0]            direction,
    output logic [DATA_WIDTH-1:0] period_speed,
    output logic                  period_valid,
    output logic                  stall,
    output logic                  quad_error
);

    localparam logic [DATA_WIDTH-1:0] c_timeout  = DATA_WIDTH'(TIMEOUT);
    localparam logic [1:0]            c_dir_fwd  = 2'b10;
    localparam logic [1:0]            c_dir_rev  = 2'b01;
    localparam logic [1:0]            c_dir_none = 2'b00;

    logic [1:0]            w_raw;      // {A, B}
    logic [1:0]            w_cur;      // filtered {A, B}
    logic [1:0]            r_prev;     // filtered {A, B} one cycle ago
    logic                  w_step_fwd;
    logic                  w_step_rev;
    logic                  w_double;
    logic                  w_a_rise;
    logic                  w_timeout_hit;
    logic [DATA_WIDTH-1:0] r_period_ctr;
    logic                  r_armed;

    assign w_raw = {encoder_a, encoder_b};

    // Index 1 is channel A, index 0 is channel B.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_chan
            logic                  r_meta;
            logic                  r_sync;
            logic [FILTER_LEN-1:0] r_shift;
            logic                  r_filt;

            // Synchronise the raw level, then accept it only once the whole
            // shift register agrees on it.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_meta  <= 1'b0;
                    r_sync  <= 1'b0;
                    r_shift <= '0;
                    r_filt  <= 1'b0;
                end else begin
                    r_meta  <= w_raw[g];
                    r_sync  <= r_meta;
                    r_shift <= {r_shift[FILTER_LEN-2:0], r_sync};
                    if (&r_shift) begin
                        r_filt <= 1'b1;
                    end else if (~|r_shift) begin
                        r_filt <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign w_cur = {g_chan[1].r_filt, g_chan[0].r_filt};

    // Classify the filtered transition as forward, reverse or illegal.
    always_comb begin
        w_step_fwd = 1'b0;
        w_step_rev = 1'b0;
        w_double   = (w_cur ^ r_prev) == 2'b11;
        case ({r_prev, w_cur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_step_fwd = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_step_rev = 1'b1;
            default: ;
        endcase
    end

    // A rising edge always beats a coincident timeout.
    assign w_a_rise      = w_cur[1] & ~r_prev[1];
    assign w_timeout_hit = enable & ~w_a_rise & (r_period_ctr == c_timeout);

    // Position, direction and illegal-transition pulse; decode runs even
    // while measurement is disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev     <= 2'b00;
            position   <= '0;
            direction  <= c_dir_none;
            quad_error <= 1'b0;
        end else begin
            r_prev     <= w_cur;
            quad_error <= w_double;
            if (clear_pos) begin
                position <= '0;
            end else if (w_step_fwd) begin
                position <= position + 1'b1;
            end else if (w_step_rev) begin
                position <= position - 1'b1;
            end
            if (w_step_fwd) begin
                direction <= c_dir_fwd;
            end else if (w_step_rev) begin
                direction <= c_dir_rev;
            end
            if (w_timeout_hit) begin
                direction <= c_dir_none;
            end
        end
    end

    // Period measurement between filtered A rising edges, with arming after
    // reset, stall or re-enable, and saturating stall detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period_ctr <= '0;
            r_armed      <= 1'b0;
            period_speed <= '1;
            period_valid <= 1'b0;
            stall        <= 1'b1;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                r_period_ctr <= '0;
                r_armed      <= 1'b0;
            end else if (w_a_rise) begin
                r_period_ctr <= '0;
                if (r_armed) begin
                    // Counter holds distance-1 at the edge.
                    period_speed <= r_period_ctr + 1'b1;
                    period_valid <= 1'b1;
                end else begin
                    r_armed <= 1'b1;
                    stall   <= 1'b0;
                end
            end else if (w_timeout_hit) begin
                stall        <= 1'b1;
                r_armed      <= 1'b0;
                period_speed <= '1;
            end else begin
                r_period_ctr <= r_period_ctr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_encoder_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_frontend
// Description : Directed self-checking bench for encoder_frontend
//               (DATA_WIDTH=16, FILTER_LEN=3, TIMEOUT=1000).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_frontend;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        encoder_a;
    logic        encoder_b;
    logic        clear_pos;
    logic [15:0] position;
    logic [1:0]  direction;
    logic [15:0] period_speed;
    logic        period_valid;
    logic        stall;
    logic        quad_error;

    int n_vec     = 0;
    int n_err     = 0;
    int valid_cnt = 0;
    int qerr_cnt  = 0;
    int v0;
    logic [15:0] last_speed = '0;

    encoder_frontend #(
        .DATA_WIDTH (16),
        .FILTER_LEN (3),
        .TIMEOUT    (1000)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .encoder_a    (encoder_a),
        .encoder_b    (encoder_b),
        .clear_pos    (clear_pos),
        .position     (position),
        .direction    (direction),
        .period_speed (period_speed),
        .period_valid (period_valid),
        .stall        (stall),
        .quad_error   (quad_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (period_valid) begin
            valid_cnt  = valid_cnt + 1;
            last_speed = period_speed;
        end
        if (quad_error) qerr_cnt = qerr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_ab(input logic a, input logic b, input int n);
        encoder_a = a;
        encoder_b = b;
        step_clk(n);
    endtask

    task automatic fwd_cycle(input int q);
        drive_ab(1'b0, 1'b1, q);
        drive_ab(1'b1, 1'b1, q);
        drive_ab(1'b1, 1'b0, q);
        drive_ab(1'b0, 1'b0, q);
    endtask

    task automatic rev_cycle(input int q);
        drive_ab(1'b1, 1'b0, q);
        drive_ab(1'b1, 1'b1, q);
        drive_ab(1'b0, 1'b1, q);
        drive_ab(1'b0, 1'b0, q);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pos"},   32'(position),     32'h0);
        check({tag, "_dir"},   32'(direction),    32'h0);
        check({tag, "_speed"}, 32'(period_speed), 32'hFFFF);
        check({tag, "_valid"}, 32'(period_valid), 32'h0);
        check({tag, "_stall"}, 32'(stall),        32'h1);
        check({tag, "_qerr"},  32'(quad_error),   32'h0);
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b1;
        encoder_a = 1'b0;
        encoder_b = 1'b0;
        clear_pos = 1'b0;
        step_clk(3);
        check_reset_state("rst");
        reset_n = 1'b1;
        step_clk(2);

        // 1: steady forward, A period 200
        drive_ab(1'b0, 1'b1, 50);
        check("t1_pos_first", 32'(position), 32'd1);
        check("t1_stall_pre", 32'(stall), 32'h1);
        drive_ab(1'b1, 1'b1, 50);
        check("t1_stall_edge1", 32'(stall), 32'h0);
        check("t1_valid_edge1", 32'(valid_cnt), 32'd0);
        drive_ab(1'b1, 1'b0, 50);
        drive_ab(1'b0, 1'b0, 50);
        for (int i = 0; i < 4; i++) fwd_cycle(50);
        check("t1_pos", 32'(position), 32'd20);
        check("t1_dir", 32'(direction), 32'h2);
        check("t1_valid_cnt", 32'(valid_cnt), 32'd4);
        check("t1_last_speed", 32'(last_speed), 32'd200);
        check("t1_speed", 32'(period_speed), 32'd200);

        // 2: reverse 8 cycles from 0
        clear_pos = 1'b1;
        step_clk(1);
        clear_pos = 1'b0;
        step_clk(1);
        check("t2_clear", 32'(position), 32'h0);
        for (int i = 0; i < 8; i++) rev_cycle(50);
        check("t2_pos", 32'(position), 32'hFFE0);
        check("t2_dir", 32'(direction), 32'h1);

        // 3: 2-clk glitch rejected, 3-clk pulse accepted
        drive_ab(1'b1, 1'b0, 2);
        drive_ab(1'b0, 1'b0, 12);
        check("t3_glitch_pos", 32'(position), 32'hFFE0);
        check("t3_glitch_dir", 32'(direction), 32'h1);
        drive_ab(1'b1, 1'b0, 3);
        drive_ab(1'b0, 1'b0, 5);
        check("t3_pulse_pos_mid", 32'(position), 32'hFFDF);
        step_clk(10);
        check("t3_pulse_pos_end", 32'(position), 32'hFFE0);
        check("t3_pulse_dir", 32'(direction), 32'h2);

        // 4: double-bit transitions
        check("t4_no_qerr_yet", 32'(qerr_cnt), 32'd0);
        drive_ab(1'b1, 1'b1, 20);
        check("t4_qerr1", 32'(qerr_cnt), 32'd1);
        check("t4_pos1", 32'(position), 32'hFFE0);
        check("t4_dir1", 32'(direction), 32'h2);
        drive_ab(1'b0, 1'b0, 20);
        check("t4_qerr2", 32'(qerr_cnt), 32'd2);
        check("t4_pos2", 32'(position), 32'hFFE0);

        // 5: 300-clk period, then stall at TIMEOUT, then re-arm
        for (int i = 0; i < 3; i++) fwd_cycle(75);
        check("t5_speed300", 32'(last_speed), 32'd300);
        v0 = valid_cnt;
        step_clk(782);
        check("t5_stall_before", 32'(stall), 32'h0);
        step_clk(1);
        check("t5_stall_after", 32'(stall), 32'h1);
        check("t5_stall_speed", 32'(period_speed), 32'hFFFF);
        check("t5_stall_dir", 32'(direction), 32'h0);
        check("t5_stall_novalid", 32'(valid_cnt), 32'(v0));
        drive_ab(1'b0, 1'b1, 100);
        drive_ab(1'b1, 1'b1, 100);
        check("t5_arm_stall", 32'(stall), 32'h0);
        check("t5_arm_novalid", 32'(valid_cnt), 32'(v0));
        check("t5_arm_speed", 32'(period_speed), 32'hFFFF);
        drive_ab(1'b1, 1'b0, 100);
        drive_ab(1'b0, 1'b0, 100);
        drive_ab(1'b0, 1'b1, 100);
        drive_ab(1'b1, 1'b1, 100);
        check("t5_valid400", 32'(valid_cnt), 32'(v0 + 1));
        check("t5_speed400", 32'(period_speed), 32'd400);
        check("t5_dir", 32'(direction), 32'h2);

        // 6a: clear_pos coincident with a step at position 5
        clear_pos = 1'b1;
        step_clk(1);
        clear_pos = 1'b0;
        drive_ab(1'b1, 1'b0, 20);
        drive_ab(1'b0, 1'b0, 20);
        drive_ab(1'b0, 1'b1, 20);
        drive_ab(1'b1, 1'b1, 20);
        drive_ab(1'b1, 1'b0, 20);
        check("t6_pos5", 32'(position), 32'd5);
        check("t6_speed161", 32'(period_speed), 32'd161);
        drive_ab(1'b0, 1'b0, 6);
        clear_pos = 1'b1;
        step_clk(1);
        clear_pos = 1'b0;
        step_clk(20);
        check("t6_clear_pri", 32'(position), 32'h0);

        // 6b: enable dropped for 50 cycles
        enable = 1'b0;
        v0 = valid_cnt;
        step_clk(50);
        check("t6_dis_novalid", 32'(valid_cnt), 32'(v0));
        check("t6_dis_speed", 32'(period_speed), 32'd161);
        check("t6_dis_stall", 32'(stall), 32'h0);
        enable = 1'b1;
        drive_ab(1'b0, 1'b1, 50);
        drive_ab(1'b1, 1'b1, 50);
        check("t6_en_arm", 32'(valid_cnt), 32'(v0));
        check("t6_en_arm_speed", 32'(period_speed), 32'd161);
        drive_ab(1'b1, 1'b0, 50);
        drive_ab(1'b0, 1'b0, 50);
        drive_ab(1'b0, 1'b1, 50);
        drive_ab(1'b1, 1'b1, 50);
        check("t6_en_valid", 32'(valid_cnt), 32'(v0 + 1));
        check("t6_en_speed", 32'(period_speed), 32'd200);

        // 6c: asynchronous reset mid-run
        drive_ab(1'b1, 1'b0, 20);
        drive_ab(1'b0, 1'b0, 20);
        reset_n = 1'b0;
        #2;
        check_reset_state("mid_rst");
        step_clk(3);
        reset_n = 1'b1;
        v0 = valid_cnt;
        drive_ab(1'b0, 1'b1, 50);
        drive_ab(1'b1, 1'b1, 50);
        check("t6_rst_arm", 32'(valid_cnt), 32'(v0));
        check("t6_rst_stall", 32'(stall), 32'h0);
        drive_ab(1'b1, 1'b0, 50);
        drive_ab(1'b0, 1'b0, 50);
        drive_ab(1'b0, 1'b1, 50);
        drive_ab(1'b1, 1'b1, 50);
        check("t6_rst_valid", 32'(valid_cnt), 32'(v0 + 1));
        check("t6_rst_speed", 32'(period_speed), 32'd200);
        check("t6_rst_pos", 32'(position), 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
